// File: rtl/s2p_pkg.sv
// Shared definitions for the serial-to-parallel receiver: default word width
// and the frame state encoding.
package s2p_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/s2p_fifo.sv
// Two-entry output buffer with a registered head; push and pop in the same
// cycle are both honoured at every occupancy, including full.
module s2p_fifo
  import s2p_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_cnt;
  logic             w_pop;

  assign w_pop = i_pop && (r_cnt != 2'd0);

  // NOTE: the storage registers are reset too, because the head drives the
  // output port directly and must read as zero out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= 2'd0;
    end else begin
      case (r_cnt)
        2'd0: begin
          if (i_push) begin
            r_head <= i_data;
            r_cnt  <= 2'd1;
          end
        end
        2'd1: begin
          if (i_push && w_pop) begin
            r_head <= i_data;
          end else if (i_push) begin
            r_tail <= i_data;
            r_cnt  <= 2'd2;
          end else if (w_pop) begin
            r_cnt  <= 2'd0;
          end
        end
        2'd2: begin
          // A push while full is only accepted when a pop frees the tail slot.
          if (w_pop) begin
            r_head <= r_tail;
            if (i_push) r_tail <= i_data;
            else        r_cnt  <= 2'd1;
          end
        end
        default: r_cnt <= 2'd0;
      endcase
    end
  end

  assign o_data  = r_head;
  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);

endmodule

// File: rtl/s2p.sv
// Serial-to-parallel receiver: shifts d_in MSB first while cs_n is low and
// hands completed words to a 2-entry valid/ready buffer.
module s2p
  import s2p_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_in,
  input  logic             cs_n,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-2:0] r_shift;
  logic [WIDTH-1:0] w_word;
  logic             w_shift_en;
  logic             w_last;
  logic             w_abort;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;
  logic             r_overrun;
  logic             r_frame_err;
  logic             r_busy;

  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples the pre-edge value of its inputs.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = cs_n ? ST_IDLE : ST_SHIFT;
  end

  // NOTE: every signal gets a default before any branch, so no path through
  // the block leaves a value held and no latch is inferred.
  always_comb begin
    w_shift_en  = 1'b0;
    w_last      = 1'b0;
    w_abort     = 1'b0;
    w_count_nxt = r_count;
    if (w_state_nxt == ST_SHIFT) begin
      w_shift_en  = 1'b1;
      w_last      = (r_count == CW'(WIDTH - 1));
      w_count_nxt = w_last ? '0 : r_count + CW'(1);
    end else if ((r_state == ST_SHIFT) && (r_count != '0)) begin
      w_abort     = 1'b1;
      w_count_nxt = '0;
    end
  end

  assign w_word  = {r_shift, d_in};
  assign m_valid = !w_empty;
  assign w_pop   = m_valid && m_ready;
  assign w_drop  = w_last && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= '0;
      r_shift     <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      if (w_shift_en) r_shift <= w_word[WIDTH-2:0];
      r_frame_err <= w_abort;
      r_busy      <= (w_count_nxt != '0);
      // A drop in the same cycle as a clear request keeps the flag set.
      if (w_drop)       r_overrun <= 1'b1;
      else if (ovr_clr) r_overrun <= 1'b0;
    end
  end

  s2p_fifo #(.WIDTH(WIDTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_last),
    .i_data  (w_word),
    .i_pop   (w_pop),
    .o_data  (m_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;

endmodule

// File: doc/s2p.md
S2P -- requirements
Module: s2p

Interface
REQ-001 Parameter WIDTH, default 8, word length in bits; legal range 2..32.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  reset is synchronous and active-high.
REQ-004 d_in  in  1  serial data bit, MSB first (MISO/MOSI loopback side).
REQ-005 cs_n  in  1  frame enable, active low; bit sampled each clk while low.
REQ-006 m_data  out  WIDTH  received word at FIFO head.
REQ-007 m_valid  out  1  m_data holds a valid word.
REQ-008 m_ready  in  1  consumer accepts word when m_valid && m_ready.
REQ-009 overrun  out  1  sticky: a completed word was dropped because the buffer was full.
REQ-010 ovr_clr  in  1  clears overrun.
REQ-011 frame_err  out  1  one-cycle pulse: frame ended with a partial word.
REQ-012 busy  out  1  high while a word is partially shifted in (bit count != 0).

Function
REQ-013 States: IDLE (cs_n high, count 0) and SHIFT (cs_n low).
REQ-014 In any cycle with cs_n low, shift_reg <= {shift_reg[WIDTH-2:0], d_in} and bit count increments.
REQ-015 When the sampled bit is the WIDTH-th of a word, the full word {shift_reg[WIDTH-2:0], d_in} is pushed and the count wraps to 0 in the same cycle.
REQ-016 Back-to-back words within one cs_n-low frame are supported with no gap cycles.
REQ-017 cs_n high with count != 0: partial word discarded, count cleared, frame_err pulses for exactly that cycle.
REQ-018 cs_n high with count == 0: no action, no frame_err.
REQ-019 Output buffer: 2-entry FIFO; push-to-m_valid latency is 1 cycle when empty.
REQ-020 Pop occurs on m_valid && m_ready; m_data shows the next entry in the following cycle.
REQ-021 Push and pop in the same cycle are both honoured at any occupancy, including full.
REQ-022 Push when full and no pop: word dropped, FIFO contents unchanged, overrun set next cycle.
REQ-023 overrun stays high until ovr_clr; if ovr_clr and a drop coincide, overrun remains set.
REQ-024 m_data is stable while m_valid && !m_ready.
REQ-025 Word bit order: first sampled bit lands in m_data[WIDTH-1].

Reset
REQ-026 On reset: count 0, shift_reg 0, FIFO empty, m_valid 0, m_data 0, overrun 0, frame_err 0, busy 0.
REQ-027 Reset mid-frame discards the partial word without frame_err; reset has priority over all other inputs.
REQ-028 First sample after reset deasserts occurs in the first cycle with reset low and cs_n low.

Structure
REQ-029 Shared package holds the WIDTH default and the IDLE/SHIFT state encoding.
REQ-030 The 2-entry buffer is a sub-module s2p_fifo (parameterised width, full/empty, simultaneous push/pop).
REQ-031 Bit counter width is clog2(WIDTH); no latches; all outputs registered except m_data/m_valid from FIFO registers.

Verification
REQ-032 WIDTH=8, cs_n low 8 cycles, d_in=1,0,1,0,0,1,0,1 -> m_data=8'hA5, m_valid high 1 cycle after 8th bit, m_ready=1 pops it.
REQ-033 cs_n low 24 cycles sending 8'h01,8'h02,8'h03, m_ready=0 -> 8'h01,8'h02 buffered, 8'h03 dropped, overrun=1; then m_ready=1 yields 01 then 02.
REQ-034 cs_n low 5 cycles then high -> frame_err one-cycle pulse, m_valid stays 0, next 8-bit frame 8'h3C received correctly.
REQ-035 FIFO full, m_ready=1 in the cycle the 3rd word completes -> no drop, overrun stays 0, words arrive in order.
REQ-036 reset asserted after 4 bits of a frame -> busy=0, no frame_err, no word, subsequent 8'hFF frame yields 8'hFF.
REQ-037 overrun set, ovr_clr pulsed -> overrun=0 next cycle; ovr_clr coincident with a drop -> overrun stays 1.
